spi_frame_rx: RTL and testbench
===============================

// Module: spi_frame_rx
// PURPOSE
//  System-clock SPI slave front end. Oversamples raw sck/sdi/nss pins, assembles FRAME_BITS-bit frames
//  MSB-first, and hands complete frames downstream (display decode, game logic) via valid/ready.
//  Sits between the SPI pins and every consumer of received words; replaces direct sck-clocked shifting.
// PARAMETERS
//  FRAME_BITS   16  bits per frame; a frame is valid only if exactly this many sck rising edges occur
//  SYNC_STAGES  2   flip-flop depth of the pin synchronizers (>=2)
// PORTS
//  clk          in   1           system clock; all logic on posedge clk
//  rst          in   1           synchronous, active-high reset
//  sck          in   1           raw SPI clock pin (mode 0); async to clk
//  sdi          in   1           raw SPI data in pin
//  nss          in   1           raw SPI chip select pin, active low
//  sdo          out  1           SPI data out (see CONFIGURATION)
//  frame_data   out  FRAME_BITS  last accepted frame, held stable while frame_valid=1
//  frame_valid  out  1           frame_data holds an unconsumed frame
//  frame_ready  in   1           consumer accepts frame when frame_valid & frame_ready
//  frame_err    out  1           one-cycle pulse: frame ended with bit count != FRAME_BITS
//  overrun      out  1           sticky: a good frame was dropped because the previous was unconsumed
// BEHAVIOUR
//  - Reset values: sdo=0, frame_data=0, frame_valid=0, frame_err=0, overrun=0, state=WAIT_IDLE, bit_cnt=0.
//  - sck, sdi, nss each pass SYNC_STAGES flops; sck/nss edges detected on synced value vs 1-cycle-delayed copy.
//  - Requirement on system: f_clk >= 8 * f_sck; sdi stable around sck rise.
//  - FSM:
//    WAIT_IDLE: ignore everything until synced nss=1 -> IDLE (prevents partial frame after reset mid-transfer).
//    IDLE: synced nss falling -> SHIFT; shreg<=0, bit_cnt<=0.
//    SHIFT: on each synced sck rising: shreg<={shreg[FRAME_BITS-2:0], sdi_s}; bit_cnt saturates at FRAME_BITS+1.
//           synced nss rising -> IDLE and evaluate frame the same cycle.
//  - Frame evaluation (nss rising cycle):
//    bit_cnt != FRAME_BITS -> frame_err=1 for that cycle; frame discarded; frame_data/frame_valid unchanged.
//    bit_cnt == FRAME_BITS and (!frame_valid | frame_ready) -> frame_data<=shreg, frame_valid<=1 next cycle.
//    bit_cnt == FRAME_BITS and frame_valid & !frame_ready -> frame dropped, overrun<=1 (cleared only by rst).
//  - Handshake: frame_valid falls the cycle after frame_valid & frame_ready unless a new frame loads that same
//    cycle (then frame_valid stays 1 with new data, no overrun). frame_data never changes while valid & !ready.
//  - Latency: frame_valid rises SYNC_STAGES+2 clk cycles after nss rising edge at the pin.
//  - sck edges while nss_s=1 are ignored. nss glitch high then low mid-frame ends that frame (error unless
//    count exact) and starts a fresh one.
//  - rst mid-frame: all state to reset values; in-flight bits lost; no output until next complete frame.
// CONFIGURATION
//  SPI_FRAME_ECHO_EN defined: on synced nss falling, tx shift reg loads current frame_data (0 after reset);
//    sdo = tx MSB; tx shifts left on each synced sck falling edge in SHIFT; sdo=0 outside SHIFT.
//    Master therefore reads back the previously accepted frame during the next transfer.
//  Not defined: no tx register; sdo tied 0.
// STRUCTURE
//  - Package spi_pkg: typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} spi_rx_state_t;
//    localparam SPI_FRAME_BITS_DEFAULT = 16.
//  - Sub-module sync_edge (param STAGES): synchronizer + rise/fall pulse outputs; instantiated for sck and nss;
//    sdi uses the synchronizer only.
// TESTING
//  1. rst, nss low, 16 bits of 16'hA5C3, nss high, ready=1 -> frame_valid 1 cycle, frame_data=16'hA5C3, err=0.
//  2. 12-bit frame, then 17-bit frame -> frame_err pulses once each, frame_valid stays 0, frame_data=0.
//  3. ready=0; frames 16'h1234 then 16'hBEEF -> frame_data=16'h1234 held, overrun=1 after 2nd.
//  4. frame_valid=1, ready asserted exactly on 2nd frame's evaluation cycle -> frame_data=2nd, valid=1, overrun=0.
//  5. rst pulsed after 7 bits with nss low, then 9 more bits, nss high -> no valid, no err; next full frame OK.
//  6. SPI_FRAME_ECHO_EN: send 16'hA5C3, consume, send 16'h0000 -> sdo bits captured on sck rise = 16'hA5C3.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame receiver.
package spi_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE,
        IDLE,
        SHIFT
    } spi_rx_state_t;

    localparam int SPI_FRAME_BITS_DEFAULT = 16;

endpackage

// File: rtl/spi_frame_rx_sync_edge.sv
// Pin synchronizer with registered rise/fall pulses, comparing the synced level
// against a one-cycle-delayed copy.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // Chain resets low so a chip select held low across reset never looks idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/spi_frame_rx.sv
// System-clock SPI mode-0 slave: oversampled pins, MSB-first frame assembly, valid/ready output.
// Optional read-back of the last accepted frame on sdo when SPI_FRAME_ECHO_EN is defined.
module spi_frame_rx
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = SPI_FRAME_BITS_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  sdi,
    input  logic                  nss,
    output logic                  sdo,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic                  frame_err,
    output logic                  overrun
);

    localparam int              CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sck_level, sck_rise, sck_fall;
    logic nss_s, nss_rise, nss_fall;
    logic sdi_s;
    logic [SYNC_STAGES-1:0] sdi_sync_q;

    spi_rx_state_t           state_q, state_d;
    logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]   frame_data_q, frame_data_d;
    logic                    frame_valid_q, frame_valid_d;
    logic                    err_q, err_d;
    logic                    overrun_q, overrun_d;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (sck),
        .level_o (sck_level),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_nss_sync (
        .clk     (clk),
        .rst     (rst),
        .pin_i   (nss),
        .level_o (nss_s),
        .rise_o  (nss_rise),
        .fall_o  (nss_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sdi_sync_q <= '0;
        end else begin
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
        end
    end

    assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = frame_valid_q & ~frame_ready;
        err_d         = 1'b0;
        overrun_d     = overrun_q;

        case (state_q)
            WAIT_IDLE: begin
                if (nss_s) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (nss_fall) begin
                    state_d   = SHIFT;
                    shreg_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            SHIFT: begin
                if (sck_rise && !nss_s) begin
                    shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
                // Chip select released: judge the frame on the count reached so far.
                if (nss_rise) begin
                    state_d = IDLE;
                    if (bit_cnt_q != CNT_FULL) begin
                        err_d = 1'b1;
                    end else if (!frame_valid_q || frame_ready) begin
                        frame_data_d  = shreg_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = err_q;
    assign overrun     = overrun_q;

`ifdef SPI_FRAME_ECHO_EN
    logic [FRAME_BITS-1:0] tx_q, tx_d;
    logic                  unused_sck;

    always_comb begin
        tx_d = tx_q;
        if (state_q == IDLE && nss_fall) begin
            tx_d = frame_data_q;
        end else if (state_q == SHIFT && sck_fall && !nss_s) begin
            tx_d = {tx_q[FRAME_BITS-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q <= '0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign sdo        = (state_q == SHIFT) ? tx_q[FRAME_BITS-1] : 1'b0;
    assign unused_sck = sck_level;
`else
    logic unused_sck;

    assign sdo        = 1'b0;
    assign unused_sck = sck_level ^ sck_fall;
`endif

endmodule

// File: tb/tb_spi_frame_rx.sv
// Randomized scoreboard bench for spi_frame_rx: a driver bit-bangs SPI frames and
// predicts results; a monitor pops expectations on every handshake or error pulse.
module tb_spi_frame_rx;

    localparam int FB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          nss = 1'b1;
    logic          frame_ready = 1'b1;
    logic          sdo;
    logic [FB-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic          overrun;

    int vectors = 0;
    int miscompares = 0;

    logic [FB-1:0] exp_q[$];
    int            err_q[$];
    logic [FB-1:0] data_m = '0;
    logic          ovr_m = 1'b0;

    logic          hold_prev = 1'b0;
    logic [FB-1:0] prev_data = '0;
    logic [FB-1:0] popped;

    spi_frame_rx #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .sck         (sck),
        .sdi         (sdi),
        .nss         (nss),
        .sdo         (sdo),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: handshakes and error pulses are matched against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            hold_prev = 1'b0;
        end else begin
            if (frame_err) begin
                check("err_expected", 32'(err_q.size() > 0), 32'd1);
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
            if (frame_valid && frame_ready) begin
                check("valid_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    popped = exp_q.pop_front();
                    check("frame_data", 32'(frame_data), 32'(popped));
                end
            end
            if (hold_prev) begin
                check("hold_data", 32'(frame_data), 32'(prev_data));
                check("hold_valid", 32'(frame_valid), 32'd1);
            end
            hold_prev = frame_valid && !frame_ready;
            prev_data = frame_data;
        end
    end

    task automatic send_bit(input logic b, output logic so);
        sdi = b;
        tick(8);
        so  = sdo;
        sck = 1'b1;
        tick(8);
        sck = 1'b0;
    endtask

    // Frame-level model: a frame counts only with exactly FB bits; a good frame
    // loads when the output is free or being consumed on that cycle, else it is lost.
    task automatic model_eval(input logic [31:0] word, input int n, input logic rdy);
        if (n != FB) begin
            err_q.push_back(n);
        end else if (rdy || exp_q.size() == 0) begin
            data_m = word[31:16];
            exp_q.push_back(word[31:16]);
        end else begin
            ovr_m = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [31:0] word, input int n, input int gap, input logic pulse_ready);
        logic [31:0] so_bits;
        logic [31:0] exp_so;
        logic [FB-1:0] tx_m;
        logic so;
        so_bits = '0;
        exp_so  = '0;
`ifdef SPI_FRAME_ECHO_EN
        tx_m = data_m;
`else
        tx_m = '0;
`endif
        nss = 1'b0;
        tick(8);
        for (int i = 0; i < n; i++) begin
            send_bit(word[31-i], so);
            so_bits = {so_bits[30:0], so};
            exp_so  = {exp_so[30:0], (i < FB) ? tx_m[FB-1-i] : 1'b0};
        end
        tick(8);
        model_eval(word, n, pulse_ready ? 1'b1 : frame_ready);
        nss = 1'b1;
        check("sdo_bits", so_bits, exp_so);
        if (pulse_ready) begin
            // Ready high only on the evaluation edge: SYNC_STAGES+2 edges after the pin rises.
            tick(3);
            frame_ready = 1'b1;
            tick(1);
            frame_ready = 1'b0;
        end
        tick(gap);
    endtask

    task automatic drain_and_check(input string tag);
        int budget;
        frame_ready = 1'b1;
        budget = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && budget < 200) begin
            tick(1);
            budget++;
        end
        check({tag, "_drain_timeout"}, 32'(exp_q.size() + err_q.size()), 32'd0);
        tick(4);
        check({tag, "_valid_idle"}, 32'(frame_valid), 32'd0);
        check({tag, "_frame_data"}, 32'(frame_data), 32'(data_m));
        check({tag, "_overrun"}, 32'(overrun), 32'(ovr_m));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        data_m = '0;
        ovr_m  = 1'b0;
        exp_q.delete();
        err_q.delete();
        tick(8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic so;
        int n;
        tick(4);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", 32'(frame_data), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_sdo", 32'(sdo), 32'd0);
        rst = 1'b0;
        tick(8);

        // Basic frame, then an all-zero frame that reads the first one back on sdo.
        send_frame({16'hA5C3, 16'h0}, 16, 24, 1'b0);
        drain_and_check("t1");
        send_frame(32'h0, 16, 24, 1'b0);
        drain_and_check("t6");

        // Short and long frames both error and leave the output untouched.
        do_reset();
        send_frame(32'hFFF0_0000, 12, 24, 1'b0);
        send_frame(32'hFFFF_8000, 17, 24, 1'b0);
        drain_and_check("t2");

        // Unconsumed frame is held; the next good frame is dropped with overrun.
        do_reset();
        frame_ready = 1'b0;
        send_frame({16'h1234, 16'h0}, 16, 24, 1'b0);
        send_frame({16'hBEEF, 16'h0}, 16, 24, 1'b0);
        check("t3_held", 32'(frame_data), 32'h1234);
        check("t3_overrun", 32'(overrun), 32'd1);
        drain_and_check("t3");

        // Consume on the same edge a new frame loads: replaced without overrun.
        do_reset();
        frame_ready = 1'b0;
        send_frame({16'h1357, 16'h0}, 16, 24, 1'b0);
        send_frame({16'h2468, 16'h0}, 16, 24, 1'b1);
        check("t4_new_data", 32'(frame_data), 32'h2468);
        check("t4_valid", 32'(frame_valid), 32'd1);
        check("t4_overrun", 32'(overrun), 32'd0);
        drain_and_check("t4");

        // Reset mid-frame: the remainder of that transfer is ignored.
        nss = 1'b0;
        tick(8);
        for (int i = 0; i < 7; i++) send_bit(1'b1, so);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        data_m = '0;
        ovr_m  = 1'b0;
        for (int i = 0; i < 9; i++) send_bit(1'b0, so);
        tick(8);
        nss = 1'b1;
        tick(24);
        drain_and_check("t5_after_rst");
        send_frame({16'hC0DE, 16'h0}, 16, 24, 1'b0);
        drain_and_check("t5_next");

        // Chip-select glitch mid-frame ends the partial frame and starts a new one.
        send_frame(32'hF800_0000, 5, 6, 1'b0);
        send_frame({16'h5A5A, 16'h0}, 16, 24, 1'b0);
        drain_and_check("glitch");

        // Random lengths and payloads with the consumer always ready.
        for (int k = 0; k < 30; k++) begin
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : FB;
            send_frame($urandom, n, 24, 1'b0);
        end
        drain_and_check("rand_ready");

        // Random good frames with a stalled consumer.
        frame_ready = 1'b0;
        for (int k = 0; k < 3; k++) send_frame($urandom, FB, 24, 1'b0);
        drain_and_check("rand_stall");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
